// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: default width, the
// RV32M/RV64M funct encoding and the decode helpers used by the top.
package muldiv_unit_pkg;

  localparam int RV32_XLEN = 32;
  typedef logic [RV32_XLEN-1:0] int_reg_t;

  // Encoding follows the M-extension funct3 field.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_funct_e;

  function automatic logic is_div(input md_funct_e f);
    return f inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem(input md_funct_e f);
    return f inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic is_signed_op1(input md_funct_e f);
    return f inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_signed_op2(input md_funct_e f);
    return f inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic want_high(input md_funct_e f);
    return f inside {MD_MULH, MD_MULHSU, MD_MULHU};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = RV32_XLEN
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  md_funct_e       funct;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, funct, op1, op2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, funct, op1, op2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit_step.sv
// UNROLL chained iterations of unsigned shift-add multiply or restoring
// divide on the {acc, lo} register pair; purely combinational.
module muldiv_unit_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] opb,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);
  logic [UNROLL:0][XLEN-1:0] acc_c;
  logic [UNROLL:0][XLEN-1:0] lo_c;

  assign acc_c[0] = acc_i;
  assign lo_c[0]  = lo_i;

  for (genvar i = 0; i < UNROLL; i++) begin : g_iter
    logic [XLEN:0] sum;
    logic [XLEN:0] shl;
    logic [XLEN:0] dif;

    // mul: lo holds the multiplier, product shifts right into it.
    assign sum = {1'b0, acc_c[i]} + {1'b0, (lo_c[i][0] ? opb : {XLEN{1'b0}})};
    // div: acc stays below opb, so dif's top bit is a clean borrow flag.
    assign shl = {acc_c[i], lo_c[i][XLEN-1]};
    assign dif = shl - {1'b0, opb};

    assign acc_c[i+1] = is_div ? (dif[XLEN] ? shl[XLEN-1:0] : dif[XLEN-1:0])
                               : sum[XLEN:1];
    assign lo_c[i+1]  = is_div ? {lo_c[i][XLEN-2:0], ~dif[XLEN]}
                               : {sum[0], lo_c[i][XLEN-1:1]};
  end

  assign acc_o = acc_c[UNROLL];
  assign lo_o  = lo_c[UNROLL];
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: magnitudes are iterated
// UNROLL bits per cycle, signs are applied in a single fix-up cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN   = RV32_XLEN,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int NITER = XLEN / UNROLL;
  localparam int CW    = $clog2(NITER + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_SPECIAL, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;
  md_funct_e       funct_q, funct_d;
  logic            neg_q, neg_d;
  logic            op1_neg_q, op1_neg_d;

  md_funct_e         fn;
  logic              s1, s2, div_zero, div_ovf, step_div;
  logic [XLEN-1:0]   mag1, mag2, spec_val, step_acc, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;

  // Any encoding outside the table (X in simulation) executes as MUL.
  always_comb begin
    case (bus.funct)
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: fn = bus.funct;
      default:                          fn = MD_MUL;
    endcase
  end

  assign s1       = is_signed_op1(fn) && bus.op1[XLEN-1];
  assign s2       = is_signed_op2(fn) && bus.op2[XLEN-1];
  assign mag1     = s1 ? -bus.op1 : bus.op1;
  assign mag2     = s2 ? -bus.op2 : bus.op2;
  assign div_zero = is_div(fn) && (bus.op2 == '0);
  assign div_ovf  = is_div(fn) && is_signed_op2(fn) && (bus.op1 == MIN_NEG) && (bus.op2 == '1);
  assign spec_val = div_zero ? (is_rem(fn) ? bus.op1 : '1)
                             : (is_rem(fn) ? '0 : bus.op1);

  assign step_div = is_div(funct_q);

  muldiv_unit_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div (step_div),
    .opb    (opb_q),
    .acc_i  (acc_q),
    .lo_i   (lo_q),
    .acc_o  (step_acc),
    .lo_o   (step_lo)
  );

  assign prod   = {acc_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    funct_d   = funct_q;
    neg_d     = neg_q;
    op1_neg_d = op1_neg_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          funct_d   = fn;
          neg_d     = s1 ^ s2;
          op1_neg_d = s1;
          opb_d     = is_div(fn) ? mag2 : mag1;
          lo_d      = is_div(fn) ? mag1 : mag2;
          acc_d     = '0;
          cnt_d     = CW'(NITER);
          // Special divides park their answer in acc for the SPECIAL cycle.
          if (div_zero || div_ovf) begin
            acc_d   = spec_val;
            state_d = S_SPECIAL;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div(funct_q)) begin
          if (is_rem(funct_q)) result_d = op1_neg_q ? -acc_q : acc_q;
          else                 result_d = neg_q ? -lo_q : lo_q;
        end else begin
          result_d = want_high(funct_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
        state_d = S_DONE;
      end
      S_SPECIAL: begin
        result_d = acc_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      funct_q   <= MD_MUL;
      neg_q     <= 1'b0;
      op1_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      funct_q   <= funct_d;
      neg_q     <= neg_d;
      op1_neg_q <= op1_neg_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;

  a_funct_known: assert property (@(posedge clk) disable iff (rst)
    (bus.in_valid && bus.in_ready) |-> !$isunknown(bus.funct));

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M/RV64M-style multiply/divide unit. Companion and successor to the single-cycle integer ALU.
- Accepts one operation at a time over a valid/ready handshake and iterates UNROLL bits per cycle.
- Returns the XLEN-bit result over a second valid/ready handshake.
- Sits beside the ALU in the execute stage. The core stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- UNROLL, 1, bits processed per iteration cycle; one of 1, 2, 4; XLEN % UNROLL == 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous abort of any in-flight or completed operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- funct  in  MDFuncts::Type  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- op1  in  XLEN  rs1 value (multiplicand / dividend).
- op2  in  XLEN  rs2 value (multiplier / divisor).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  result value.

Behaviour:
- Reset (async assert): state=IDLE, in_ready=1, out_valid=0, result=0. All internal registers cleared. Reset mid-operation discards the operation.
- Handshake: request accepted on a rising edge with in_valid && in_ready. funct/op1/op2 are captured that edge and need not be held afterwards.
- Result transfer: completes on an edge with out_valid && out_ready. result is held stable while out_valid=1 && !out_ready.
- States:
  - IDLE: in_ready=1. On accept, go to SPECIAL if the operation is a special divide case, else go to CALC with cnt=XLEN/UNROLL.
  - CALC: perform UNROLL iterations per cycle (shift-add multiply / restoring divide) on magnitudes. Decrement cnt; when cnt reaches 1, go to FIX.
  - FIX: one cycle. Select the upper or lower product half, or the quotient or remainder. Negate if the sign rule requires it. Go to DONE.
  - SPECIAL: one cycle. Load the special-case result. Go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Latency, accept edge to first cycle out_valid=1:
  - Normal operations: XLEN/UNROLL+1 cycles.
  - Special cases: 1 cycle.
  - XLEN=32, UNROLL=1 gives 33 cycles.
- Sign rules:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Magnitudes are taken at accept. Product is negated if the operand signs differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Product width is 2*XLEN. MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Special cases (SPECIAL path):
  - Divide by zero: DIV/DIVU → all ones. REM/REMU → op1.
  - Signed overflow, op1 = -2^(XLEN-1) and op2 = -1: DIV → op1. REM → 0.
  - Multiplies never take the SPECIAL path.
- flush:
  - In CALC, FIX, SPECIAL or DONE: go to IDLE next edge, out_valid=0, result is discarded.
  - In IDLE: takes priority over in_valid; no accept that edge.
  - flush and out_ready in DONE on the same edge: the transfer does not count.
- Illegal funct value: treated as MUL. Assertion fires in simulation.

Decomposition:
- MDFuncts package: enum Type for the 8 functs; helper functions is_div, is_signed_op1, is_signed_op2, want_high.
- Reuse RV32Consts XLEN/IntReg for the default width. Parameter XLEN overrides it locally.
- State enum (IDLE, CALC, FIX, SPECIAL, DONE) local to the module.
- One natural sub-module: muldiv_step. Combinational, parametrised by XLEN and UNROLL. Performs UNROLL shift-add or restoring-subtract iterations on the {acc, quotient/multiplier} pair. Instantiated once and reused for both mul and div.

Test Plan:
- MUL 7 × 0xFFFFFFFD (XLEN=32, UNROLL=1) → result 0xFFFFFFEB, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD, REM −7%2 → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2; repeat all with UNROLL=4 and latency 9.
- DIVU 5/0 → 0xFFFFFFFF, REM 5%0 → 5, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM of the same operands → 0; each with out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result/out_valid stable, in_ready=0. Release → in_ready=1 the next cycle. Back-to-back ops return correct results in order.
- Flush at cycle 5 of CALC → out_valid never rises, IDLE next cycle. Assert rst asynchronously mid-CALC → out_valid=0, in_ready=1 immediately. Subsequent DIV 9/3 → 3.
